// File: rtl/edge_marker_pkg.sv
// rtl/edge_marker_pkg.sv - edge code values, frame geometry and FSM state type for edge_marker
package edge_marker_pkg;

    localparam int FRAME_W      = 640;
    localparam int FRAME_H      = 480;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    // Shared with the contour tracer, which rewrites candidates to traced/cleared.
    localparam logic [2:0] EDGE_NONE    = 3'b000;
    localparam logic [2:0] EDGE_CAND    = 3'b011;
    localparam logic [2:0] EDGE_TRACED  = 3'b111;
    localparam logic [2:0] EDGE_CLEARED = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Neighbour inputs are already forced to background when outside the frame.
    function automatic logic [2:0] classify(input logic c, input logic up, input logic dn,
                                            input logic lf, input logic rt);
        return (c && !(up && dn && lf && rt)) ? EDGE_CAND : EDGE_NONE;
    endfunction

endpackage

// File: rtl/edge_marker_if.sv
// rtl/edge_marker_if.sv - mask BRAM read port and edge BRAM write port bundle
interface edge_marker_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] mask_addr;
    logic              mask_data;
    logic              edge_we;
    logic [ADDR_W-1:0] edge_addr_write;
    logic [2:0]        bram_write;

    modport master (
        output mask_addr,
        input  mask_data,
        output edge_we,
        output edge_addr_write,
        output bram_write
    );

    modport slave (
        input  mask_addr,
        output mask_data,
        input  edge_we,
        input  edge_addr_write,
        input  bram_write
    );
endinterface

// File: rtl/edge_marker_line_buffer.sv
// rtl/edge_marker_line_buffer.sv - WIDTH-deep 1-bit delay line advancing only when en is high
module edge_marker_line_buffer #(
    parameter int WIDTH = 640
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout
);
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d = {mem_q[WIDTH-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[WIDTH-1];

endmodule

// File: rtl/edge_marker.sv
// rtl/edge_marker.sv - raster scan of the foreground mask, writing an edge code per pixel
module edge_marker
    import edge_marker_pkg::*;
#(
    parameter int WIDTH        = FRAME_W,
    parameter int HEIGHT       = FRAME_H,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    edge_marker_if.master     bram,
    output logic [ADDR_W-1:0] edge_count,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] FIRST_CTR = ADDR_W'(WIDTH + 1);
    localparam logic [ADDR_W-1:0] FLUSH_END = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_Y    = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]       fl_cnt_q, fl_cnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] fls_q, fls_d;
    logic [ADDR_W-1:0]       in_idx_q, in_idx_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       cx_q, cx_d;
    logic [ADDR_W-1:0]       cy_q, cy_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [2:0]              code_q, code_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    d1_q, d1_d;
    logic                    a1_q, a1_d;
    logic                    a2_q, a2_d;
    logic                    b1_q, b1_d;

    logic       push, push_flush;
    logic       in_valid, in_pix, centre_ok;
    logic       lb_a_out, lb_b_out;
    logic       nb_up, nb_dn, nb_lf, nb_rt;
    logic [2:0] cls;

    // Flush slots travel through the same tag pipe so they land right behind the last read.
    assign in_valid  = vld_q[READ_LATENCY-1];
    assign in_pix    = in_valid & ~fls_q[READ_LATENCY-1] & bram.mask_data;
    assign centre_ok = in_valid && (in_idx_q >= FIRST_CTR);

    // Centre is input i-WIDTH-1; down is the previous input, right is buffer A's tap.
    assign nb_up = (cy_q != '0) && b1_q;
    assign nb_dn = (cy_q != LAST_Y) && d1_q;
    assign nb_lf = (cx_q != '0) && a2_q;
    assign nb_rt = (cx_q != LAST_X) && lb_a_out;
    assign cls   = classify(a1_q, nb_up, nb_dn, nb_lf, nb_rt);

    edge_marker_line_buffer #(.WIDTH(WIDTH)) u_lb_a (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (in_valid),
        .din  (in_pix),
        .dout (lb_a_out)
    );

    edge_marker_line_buffer #(.WIDTH(WIDTH)) u_lb_b (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (in_valid),
        .din  (lb_a_out),
        .dout (lb_b_out)
    );

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        fl_cnt_d   = fl_cnt_q;
        in_idx_d   = in_idx_q;
        wr_ptr_d   = wr_ptr_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        we_d       = 1'b0;
        waddr_d    = '0;
        code_d     = EDGE_NONE;
        cnt_d      = cnt_q;
        done_d     = done_q;
        d1_d       = d1_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        b1_d       = b1_q;
        push       = 1'b0;
        push_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    state_d   = ST_READ;
                    rd_addr_d = '0;
                end
            end
            ST_READ: begin
                push      = 1'b1;
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_addr_q == LAST_PIX) begin
                    state_d   = ST_FLUSH;
                    rd_addr_d = '0;
                    fl_cnt_d  = '0;
                end
            end
            ST_FLUSH: begin
                push       = 1'b1;
                push_flush = 1'b1;
                fl_cnt_d   = fl_cnt_q + 1'b1;
                if (fl_cnt_q == FLUSH_END) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (we_q && waddr_q == LAST_PIX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        vld_d = (vld_q << 1) | READ_LATENCY'(push);
        fls_d = (fls_q << 1) | READ_LATENCY'(push_flush);

        if (in_valid) begin
            in_idx_d = in_idx_q + 1'b1;
            d1_d     = in_pix;
            a1_d     = lb_a_out;
            a2_d     = a1_q;
            b1_d     = lb_b_out;
        end

        if (centre_ok) begin
            we_d     = 1'b1;
            waddr_d  = wr_ptr_q;
            code_d   = cls;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (cls == EDGE_CAND && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cx_q == LAST_X) begin
                cx_d = '0;
                cy_d = (cy_q == LAST_Y) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end

        if (!start) begin
            state_d   = ST_IDLE;
            rd_addr_d = '0;
            fl_cnt_d  = '0;
            vld_d     = '0;
            fls_d     = '0;
            in_idx_d  = '0;
            wr_ptr_d  = '0;
            cx_d      = '0;
            cy_d      = '0;
            we_d      = 1'b0;
            waddr_d   = '0;
            code_d    = EDGE_NONE;
            cnt_d     = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            fl_cnt_q  <= '0;
            vld_q     <= '0;
            fls_q     <= '0;
            in_idx_q  <= '0;
            wr_ptr_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            code_q    <= EDGE_NONE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            d1_q      <= 1'b0;
            a1_q      <= 1'b0;
            a2_q      <= 1'b0;
            b1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            fl_cnt_q  <= fl_cnt_d;
            vld_q     <= vld_d;
            fls_q     <= fls_d;
            in_idx_q  <= in_idx_d;
            wr_ptr_q  <= wr_ptr_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            d1_q      <= d1_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            b1_q      <= b1_d;
        end
    end

    assign bram.mask_addr       = rd_addr_q;
    assign bram.edge_we         = we_q;
    assign bram.edge_addr_write = waddr_q;
    assign bram.bram_write      = code_q;
    assign edge_count           = cnt_q;
    assign done                 = done_q;

endmodule
